// File: rtl/system_bus_tracker.sv
// Single-manager bus tracker: decodes accesses onto NUM_DEVICES memory-mapped devices,
// tracks one outstanding transaction and turns decode misses and timeouts into error responses.
module system_bus_tracker #(
    parameter int          NUM_DEVICES    = 2,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF,
    localparam int         STRB           = DATA_WIDTH / 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [ADDR_WIDTH-1:0]             manager_rw_address,
    input  logic                              manager_read_request,
    input  logic                              manager_write_request,
    input  logic [DATA_WIDTH-1:0]             manager_write_data,
    input  logic [STRB-1:0]                   manager_write_strobe,
    output logic [DATA_WIDTH-1:0]             manager_read_data,
    output logic                              manager_read_response,
    output logic                              manager_write_response,
    output logic                              manager_access_error,
    output logic [ADDR_WIDTH-1:0]             device_rw_address,
    output logic [DATA_WIDTH-1:0]             device_write_data,
    output logic [STRB-1:0]                   device_write_strobe,
    output logic [NUM_DEVICES-1:0]            device_read_request,
    output logic [NUM_DEVICES-1:0]            device_write_request,
    input  logic [NUM_DEVICES*DATA_WIDTH-1:0] device_read_data,
    input  logic [NUM_DEVICES-1:0]            device_read_response,
    input  logic [NUM_DEVICES-1:0]            device_write_response,
    input  logic [NUM_DEVICES*ADDR_WIDTH-1:0] device_start_address,
    input  logic [NUM_DEVICES*ADDR_WIDTH-1:0] device_region_size,
    output logic [15:0]                       error_count,
    output logic [ADDR_WIDTH-1:0]             error_address
);

    // state | meaning
    // IDLE  | no transaction outstanding
    // WAIT  | request forwarded, waiting for the selected device's response or timeout
    // ERR   | one-cycle error response (decode miss or timeout)
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} state_t;

    localparam int                  CW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]       CNT_LAST   = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA_W = DATA_WIDTH'(ERROR_DATA);

    state_t                  state_q, state_d;
    logic [NUM_DEVICES-1:0]  sel_q, sel_d;
    logic                    kind_q, kind_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

    logic [NUM_DEVICES-1:0]  hit_sel;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    req_rd, req_wr, new_req, dev_resp, accept;

    assign req_rd  = manager_read_request;
    assign req_wr  = manager_write_request & ~manager_read_request;
    assign new_req = req_rd | req_wr;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_sel = '0;
        for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
            if ((manager_rw_address & ~(device_region_size[i*ADDR_WIDTH +: ADDR_WIDTH] - ADDR_WIDTH'(1)))
                    == device_start_address[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (sel_q[i]) sel_rdata = device_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign dev_resp = (state_q == ST_WAIT) &&
                      (|(sel_q & (kind_q ? device_read_response : device_write_response)));
    assign accept   = (state_q == ST_IDLE) || (state_q == ST_ERR) || dev_resp;

    assign device_read_request  = hit_sel & {NUM_DEVICES{req_rd & reset}};
    assign device_write_request = hit_sel & {NUM_DEVICES{req_wr & reset}};
    assign device_rw_address    = manager_rw_address   & {ADDR_WIDTH{reset}};
    assign device_write_data    = manager_write_data   & {DATA_WIDTH{reset}};
    assign device_write_strobe  = manager_write_strobe & {STRB{reset}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            kind_q     <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            kind_q     <= kind_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (dev_resp) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_d = ST_ERR;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A new request in a response cycle is taken immediately, giving zero-bubble back-to-back.
        if (accept && new_req) begin
            kind_d  = req_rd;
            addr_d  = manager_rw_address;
            sel_d   = hit_sel;
            cnt_d   = '0;
            state_d = (|hit_sel) ? ST_WAIT : ST_ERR;
        end
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (state_d == ST_ERR) begin
            err_addr_d = addr_d;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_comb begin
        manager_read_response  = 1'b0;
        manager_write_response = 1'b0;
        manager_access_error   = 1'b0;
        manager_read_data      = '0;
        if (dev_resp) begin
            manager_read_response  = kind_q;
            manager_write_response = ~kind_q;
            if (kind_q) manager_read_data = sel_rdata;
        end else if (state_q == ST_ERR) begin
            manager_read_response  = kind_q;
            manager_write_response = ~kind_q;
            manager_access_error   = 1'b1;
            if (kind_q) manager_read_data = ERR_DATA_W;
        end
    end

    assign error_count   = err_cnt_q;
    assign error_address = err_addr_q;

endmodule

// File: tb/tb_system_bus_tracker.sv
// Bench for system_bus_tracker: table vectors, hand-written multi-cycle sequences and
// randomized transactions checked against an address-range reference model.
module tb_system_bus_tracker;

    localparam int T = 8;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        int          dly;
        logic [31:0] rdata;
        logic [1:0]  exp_req;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_rd, m_wr, m_rresp, m_wresp, m_err;
    logic [3:0]  m_strb, d_strb;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_rd_req, d_wr_req, dev_rresp, dev_wresp;
    logic [31:0] dev_start [2];
    logic [31:0] dev_size  [2];
    logic [31:0] dev_rdata [2];
    logic [15:0] err_cnt;
    logic [31:0] err_addr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_cnt = 0;
    logic [31:0] exp_eaddr = '0;
    vec_t        tbl [10];

    always #5 clock = ~clock;

    system_bus_tracker #(
        .NUM_DEVICES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T), .ERROR_DATA(32'hDEADBEEF)
    ) dut (
        .clock(clock), .reset(reset),
        .manager_rw_address(m_addr), .manager_read_request(m_rd),
        .manager_write_request(m_wr), .manager_write_data(m_wdata),
        .manager_write_strobe(m_strb), .manager_read_data(m_rdata),
        .manager_read_response(m_rresp), .manager_write_response(m_wresp),
        .manager_access_error(m_err),
        .device_rw_address(d_addr), .device_write_data(d_wdata),
        .device_write_strobe(d_strb), .device_read_request(d_rd_req),
        .device_write_request(d_wr_req),
        .device_read_data({dev_rdata[1], dev_rdata[0]}),
        .device_read_response(dev_rresp), .device_write_response(dev_wresp),
        .device_start_address({dev_start[1], dev_start[0]}),
        .device_region_size({dev_size[1], dev_size[0]}),
        .error_count(err_cnt), .error_address(err_addr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Reference decode: first device whose [start, start+size) range holds the address.
    function automatic int model_target(input logic [31:0] a);
        for (int i = 0; i < 2; i++) begin
            if (64'(a) >= 64'(dev_start[i]) && 64'(a) < 64'(dev_start[i]) + 64'(dev_size[i]))
                return i;
        end
        return -1;
    endfunction

    task automatic note_error(input logic [31:0] a);
        if (exp_cnt < 65535) exp_cnt++;
        exp_eaddr = a;
    endtask

    task automatic run_txn(input vec_t v);
        int          s, rk, lat;
        logic        g_rr, g_wr, g_err;
        logic [31:0] g_data, wd;
        logic [3:0]  st;
        s  = (v.exp_req == 2'b10) ? 1 : ((v.exp_req == 2'b01) ? 0 : -1);
        rk = (v.dly >= 0) ? v.dly + 1 : -1;
        wd = $urandom;
        st = 4'($urandom_range(0, 15));
        g_rr = 1'b0; g_wr = 1'b0; g_err = 1'b0; g_data = '0; lat = -1;
        dev_rdata[0] = ~v.rdata;
        dev_rdata[1] = ~v.rdata;
        if (s >= 0) dev_rdata[s] = v.rdata;
        m_addr = v.addr; m_rd = v.rd; m_wr = ~v.rd; m_wdata = wd; m_strb = st;
        @(negedge clock);
        chk("dev_rd_req", 64'(d_rd_req), 64'(v.rd ? v.exp_req : 2'b00));
        chk("dev_wr_req", 64'(d_wr_req), 64'(v.rd ? 2'b00 : v.exp_req));
        chk("fwd_addr", 64'(d_addr), 64'(v.addr));
        chk("fwd_wdata", 64'({d_strb, d_wdata}), 64'({st, wd}));
        chk("idle_quiet", 64'({m_rresp, m_wresp, m_err}), 64'(0));
        next_cycle();
        m_rd = 1'b0; m_wr = 1'b0;
        for (int k = 1; k <= T + 3 && lat < 0; k++) begin
            dev_rresp = '0; dev_wresp = '0;
            if (s >= 0) begin
                dev_rresp[1-s] = 1'b1;
                dev_wresp[1-s] = 1'b1;
                if (v.rd) dev_wresp[s] = 1'b1; else dev_rresp[s] = 1'b1;
                if (k == rk) begin
                    if (v.rd) dev_rresp[s] = 1'b1; else dev_wresp[s] = 1'b1;
                end
            end
            @(negedge clock);
            if (m_rresp || m_wresp) begin
                lat = k; g_rr = m_rresp; g_wr = m_wresp; g_err = m_err; g_data = m_rdata;
            end
            next_cycle();
        end
        dev_rresp = '0; dev_wresp = '0;
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("resp_kind", 64'({g_rr, g_wr}), 64'(v.rd ? 2'b10 : 2'b01));
        chk("resp_err", 64'(g_err), 64'(v.exp_err));
        chk("resp_data", 64'(g_data), 64'(v.exp_data));
        if (v.exp_err) note_error(v.addr);
        for (int p = 0; p < 2; p++) begin
            if (p == 1 && v.exp_err && s >= 0) begin
                if (v.rd) dev_rresp[s] = 1'b1; else dev_wresp[s] = 1'b1;
            end
            @(negedge clock);
            chk("post_quiet", 64'({m_rresp, m_wresp, m_err}), 64'(0));
            next_cycle();
            dev_rresp = '0; dev_wresp = '0;
        end
        chk("err_count", 64'(err_cnt), 64'(exp_cnt));
        chk("err_addr", 64'(err_addr), 64'(exp_eaddr));
    endtask

    task automatic run_random(input int n);
        vec_t v;
        int   c, tgt;
        logic ok;
        for (int i = 0; i < n; i++) begin
            c = int'($urandom_range(0, 3));
            case (c)
                0:       v.addr = 32'($urandom_range(0, 32'hFFF));
                1:       v.addr = 32'h8000_0000 + 32'($urandom_range(0, 255));
                2:       v.addr = $urandom;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       v.addr = 32'h0000_1000;
                        1:       v.addr = 32'h8000_00FF;
                        2:       v.addr = 32'h8000_0100;
                        default: v.addr = 32'h0000_0FFF;
                    endcase
                end
            endcase
            v.rd    = 1'($urandom_range(0, 1));
            v.dly   = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T));
            v.rdata = $urandom;
            tgt     = model_target(v.addr);
            ok      = (tgt >= 0) && (v.dly >= 0) && (v.dly + 1 <= T - 1);
            v.exp_req = (tgt < 0) ? 2'b00 : ((tgt == 0) ? 2'b01 : 2'b10);
            if (tgt < 0)  v.exp_lat = 1;
            else if (ok)  v.exp_lat = v.dly + 1;
            else          v.exp_lat = T;
            v.exp_err  = ~ok;
            if (!v.rd)     v.exp_data = '0;
            else if (ok)   v.exp_data = v.rdata;
            else           v.exp_data = 32'hDEADBEEF;
            run_txn(v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h8000_0010, 1'b1,  0, 32'h1234_5678, 2'b10, 1, 1'b0, 32'h1234_5678};
        tbl[1] = '{32'h4000_0000, 1'b0, -1, 32'h0,         2'b00, 1, 1'b1, 32'h0};
        tbl[2] = '{32'h0000_0FFC, 1'b1,  3, 32'hA5A5_0F0F, 2'b01, 4, 1'b0, 32'hA5A5_0F0F};
        tbl[3] = '{32'h0000_0100, 1'b1, -1, 32'h0,         2'b01, T, 1'b1, 32'hDEAD_BEEF};
        tbl[4] = '{32'h8000_00FF, 1'b0,  0, 32'h0,         2'b10, 1, 1'b0, 32'h0};
        tbl[5] = '{32'h8000_0100, 1'b1, -1, 32'h0,         2'b00, 1, 1'b1, 32'hDEAD_BEEF};
        tbl[6] = '{32'h0000_1000, 1'b0, -1, 32'h0,         2'b00, 1, 1'b1, 32'h0};
        tbl[7] = '{32'h0000_0040, 1'b0, -1, 32'h0,         2'b01, T, 1'b1, 32'h0};
        tbl[8] = '{32'h0000_0004, 1'b0,  6, 32'h0,         2'b01, 7, 1'b0, 32'h0};
        tbl[9] = '{32'h8000_0080, 1'b1,  7, 32'h1111_2222, 2'b10, T, 1'b1, 32'hDEAD_BEEF};

        dev_start[0] = 32'h0000_0000; dev_size[0] = 32'h1000;
        dev_start[1] = 32'h8000_0000; dev_size[1] = 32'h100;
        dev_rdata[0] = '0; dev_rdata[1] = '0;
        dev_rresp = '0; dev_wresp = '0;
        m_wdata = '0; m_strb = '0; m_wr = 1'b0;
        m_addr = 32'h8000_0010; m_rd = 1'b1;
        reset = 1'b0;

        // Held in reset with a live request: nothing may leak out.
        repeat (2) next_cycle();
        @(negedge clock);
        chk("rst_dev_req", 64'({d_rd_req, d_wr_req}), 64'(0));
        chk("rst_resp", 64'({m_rresp, m_wresp, m_err}), 64'(0));
        chk("rst_rdata", 64'(m_rdata), 64'(0));
        chk("rst_err_count", 64'(err_cnt), 64'(0));
        chk("rst_err_addr", 64'(err_addr), 64'(0));
        next_cycle();
        m_rd = 1'b0;
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // Back-to-back: write to dev0 issued in the cycle dev1 answers a read.
        m_addr = 32'h8000_0010; m_rd = 1'b1;
        dev_rdata[1] = 32'h1234_5678; dev_rdata[0] = 32'h0;
        @(negedge clock);
        chk("b2b_rd_req", 64'(d_rd_req), 64'(2'b10));
        next_cycle();
        m_rd = 1'b0; m_addr = 32'h0000_0020; m_wr = 1'b1; dev_rresp = 2'b10;
        @(negedge clock);
        chk("b2b_rd_resp", 64'({m_rresp, m_wresp, m_err}), 64'(3'b100));
        chk("b2b_rd_data", 64'(m_rdata), 64'(32'h1234_5678));
        chk("b2b_wr_req", 64'(d_wr_req), 64'(2'b01));
        next_cycle();
        m_wr = 1'b0; dev_rresp = 2'b00; dev_wresp = 2'b01;
        @(negedge clock);
        chk("b2b_wr_resp", 64'({m_rresp, m_wresp, m_err}), 64'(3'b010));
        next_cycle();
        dev_wresp = 2'b00;
        @(negedge clock);
        chk("b2b_quiet", 64'({m_rresp, m_wresp, m_err}), 64'(0));
        next_cycle();

        // Back-to-back out of an error cycle.
        m_addr = 32'h4000_0000; m_wr = 1'b1;
        @(negedge clock);
        chk("miss_no_req", 64'({d_rd_req, d_wr_req}), 64'(0));
        next_cycle();
        m_wr = 1'b0; m_addr = 32'h8000_0020; m_rd = 1'b1; dev_rdata[1] = 32'hCAFE_F00D;
        note_error(32'h4000_0000);
        @(negedge clock);
        chk("err_b2b_resp", 64'({m_rresp, m_wresp, m_err}), 64'(3'b011));
        chk("err_b2b_data", 64'(m_rdata), 64'(0));
        chk("err_b2b_req", 64'(d_rd_req), 64'(2'b10));
        chk("err_b2b_count", 64'(err_cnt), 64'(exp_cnt));
        chk("err_b2b_addr", 64'(err_addr), 64'(exp_eaddr));
        next_cycle();
        m_rd = 1'b0; dev_rresp = 2'b10;
        @(negedge clock);
        chk("err_b2b_rd", 64'({m_rresp, m_wresp, m_err}), 64'(3'b100));
        chk("err_b2b_rdata", 64'(m_rdata), 64'(32'hCAFE_F00D));
        next_cycle();
        dev_rresp = 2'b00;

        // Read and write together: read wins, a write response is not accepted.
        m_addr = 32'h8000_0004; m_rd = 1'b1; m_wr = 1'b1; dev_rdata[1] = 32'h0BAD_CAFE;
        @(negedge clock);
        chk("both_req", 64'({d_rd_req, d_wr_req}), 64'(4'b1000));
        next_cycle();
        m_rd = 1'b0; m_wr = 1'b0; dev_wresp = 2'b10;
        @(negedge clock);
        chk("both_wr_ignored", 64'({m_rresp, m_wresp, m_err}), 64'(0));
        next_cycle();
        dev_wresp = 2'b00; dev_rresp = 2'b10;
        @(negedge clock);
        chk("both_rd_resp", 64'({m_rresp, m_wresp, m_err}), 64'(3'b100));
        chk("both_rd_data", 64'(m_rdata), 64'(32'h0BAD_CAFE));
        next_cycle();
        dev_rresp = 2'b00;

        // Overlapping regions: lowest index wins.
        dev_start[1] = 32'h0; dev_size[1] = 32'h100;
        m_addr = 32'h0000_0010; m_rd = 1'b1; dev_rdata[0] = 32'h0000_55AA;
        @(negedge clock);
        chk("overlap_req", 64'(d_rd_req), 64'(2'b01));
        next_cycle();
        m_rd = 1'b0; dev_rresp = 2'b01;
        @(negedge clock);
        chk("overlap_resp", 64'({m_rresp, m_err}), 64'(2'b10));
        chk("overlap_data", 64'(m_rdata), 64'(32'h0000_55AA));
        next_cycle();
        dev_rresp = 2'b00;
        dev_start[1] = 32'h8000_0000; dev_size[1] = 32'h100;

        run_random(80);

        // Reset in the middle of WAIT abandons the transaction.
        m_addr = 32'h8000_0010; m_rd = 1'b1;
        next_cycle();
        #1;
        reset = 1'b0;
        #1;
        chk("rstw_dev_req", 64'({d_rd_req, d_wr_req}), 64'(0));
        chk("rstw_resp", 64'({m_rresp, m_wresp, m_err}), 64'(0));
        chk("rstw_fwd_addr", 64'(d_addr), 64'(0));
        chk("rstw_err_count", 64'(err_cnt), 64'(0));
        chk("rstw_err_addr", 64'(err_addr), 64'(0));
        m_rd = 1'b0;
        next_cycle();
        reset = 1'b1;
        exp_cnt = 0; exp_eaddr = '0;
        next_cycle();
        dev_rresp = 2'b10;
        @(negedge clock);
        chk("rstw_stale", 64'({m_rresp, m_wresp, m_err}), 64'(0));
        next_cycle();
        dev_rresp = 2'b00;
        @(negedge clock);
        chk("rstw_count_after", 64'(err_cnt), 64'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/system_bus_tracker.md
Name: system_bus_tracker

Overview:
- Parametrised successor to the single-manager system bus: decodes manager accesses onto NUM_DEVICES memory-mapped devices and tracks one outstanding transaction.
- Adds what the earlier bus lacks: configurable widths, a response timeout, a decode-miss/timeout error response, and error status registers.
- Sits between the Processor Core IP manager port and the device ports (RAM, UART, timer, GPIO, ...).

Parameters:
- NUM_DEVICES, 2, number of managed devices (>=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8); strobe width STRB = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, cycles to wait for a device response before erroring (>=2).
- ERROR_DATA, 32'hDEADBEEF, read data returned on error (truncated or zero-extended to DATA_WIDTH).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- manager_rw_address  in  ADDR_WIDTH  access address
- manager_read_request  in  1  single-cycle read request pulse
- manager_write_request  in  1  single-cycle write request pulse
- manager_write_data  in  DATA_WIDTH  write data
- manager_write_strobe  in  STRB  byte enables
- manager_read_data  out  DATA_WIDTH  read data, valid with read response
- manager_read_response  out  1  read completed, one cycle
- manager_write_response  out  1  write completed, one cycle
- manager_access_error  out  1  qualifies the current response as error
- device_rw_address, device_write_data, device_write_strobe  out  ADDR_WIDTH/DATA_WIDTH/STRB  forwarded from manager
- device_read_request, device_write_request  out  NUM_DEVICES  one-hot requests
- device_read_data  in  NUM_DEVICES*DATA_WIDTH  per-device read data
- device_read_response, device_write_response  in  NUM_DEVICES  per-device responses
- device_start_address, device_region_size  in  NUM_DEVICES*ADDR_WIDTH  per-device base and power-of-two size
- error_count  out  16  saturating count of error responses
- error_address  out  ADDR_WIDTH  address of the most recent errored access

Behaviour:
- Decode: hit[i] = (addr & ~(size[i]-1)) == start[i]. Multiple hits: lowest index wins; sel is always one-hot or zero.
- device_*_request = sel & manager_*_request, combinational, only in the request cycle. Forced to 0 while reset is low.
- Read and write requests asserted together: read wins, write ignored.
- Manager sends a new request only in IDLE or in the cycle a response is presented.
- FSM states:
  - IDLE: request with hit -> WAIT; capture sel, kind (R/W), address; clear cnt. Request with miss -> ERR; capture address and kind.
  - WAIT: selected device's matching-kind response high -> forward response and read_data that cycle (combinational), error=0. Next state: IDLE, or back into WAIT/ERR if a new request arrives in the same cycle (zero-bubble back-to-back).
  - WAIT, no response: cnt++. When cnt == TIMEOUT_CYCLES-1 with no response -> ERR. A late device response after a timeout is ignored.
  - ERR: one cycle; assert the captured-kind response, manager_access_error=1, read_data=ERROR_DATA (reads only, else 0). Next state IDLE, or WAIT/ERR on a simultaneous new request.
- Response of the non-captured kind and responses from unselected devices are ignored.
- Outputs when no response: responses=0, error=0, read_data=0.
- Latency: hit with same-cycle device response -> manager response 1 cycle after request. Miss -> error response 1 cycle after request. Timeout -> error response TIMEOUT_CYCLES cycles after request.
- On entry to ERR: error_count increments and saturates at 16'hFFFF; error_address <= captured address.
- Reset (async assert, sync-safe deassert): state=IDLE, cnt=0, sel/kind=0, error_count=0, error_address=0, all responses and error=0. Reset mid-WAIT abandons the transaction; a later device response is ignored.

Test Plan:
- NUM_DEVICES=2, dev0 at 0x0000_0000 size 0x1000, dev1 at 0x8000_0000 size 0x100. Read 0x8000_0010; dev1 responds next cycle with 0x1234_5678 -> device_read_request=2'b10; manager_read_response=1 with 0x1234_5678 one cycle later; error=0.
- Write to 0x4000_0000 (no device) -> no device request; next cycle write_response=1, error=1; error_count=1, error_address=0x4000_0000.
- Read dev0 with no response, TIMEOUT_CYCLES=8 -> read_response=1, error=1, read_data=0xDEADBEEF exactly 8 cycles after request. A dev0 response 2 cycles later is ignored.
- Back-to-back: new write to dev0 in the same cycle as dev1's read response -> read completes; write_request=2'b01 that cycle; write response forwarded when dev0 responds; no bubble.
- Overlapping regions (dev1 = 0x0000_0000 size 0x100), read 0x10 -> only dev0 requested.
- Reset pulled low mid-WAIT -> all outputs 0 immediately. After release, a stale device response produces no manager response; error_count stays 0.
